// File: rtl/dht11_pkg.sv
// Shared definitions for the DHT11 result decoder: FSM encoding, status codes
// and the byte positions inside the 40-bit sensor frame.
package dht11_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_START   = 3'd1,
    S_WAIT    = 3'd2,
    S_CHECK   = 3'd3,
    S_RESPOND = 3'd4
  } state_t;

  localparam logic [1:0] ST_OK       = 2'b00;
  localparam logic [1:0] ST_CHECKSUM = 2'b01;
  localparam logic [1:0] ST_SENSOR   = 2'b10;
  localparam logic [1:0] ST_TIMEOUT  = 2'b11;

  localparam int HUM_INT_LSB = 32;
  localparam int HUM_DEC_LSB = 24;
  localparam int TMP_INT_LSB = 16;
  localparam int TMP_DEC_LSB = 8;
  localparam int CSUM_LSB    = 0;

  function automatic logic [7:0] frame_byte(input logic [39:0] frame, input int lsb);
    return frame[lsb +: 8];
  endfunction

endpackage

// File: rtl/dht11_checksum.sv
// Combinational DHT11 frame check: the four data bytes summed modulo 256
// must equal the trailing checksum byte.
module dht11_checksum
  import dht11_pkg::*;
(
  input  logic [39:0] frame,
  output logic        ok
);

  logic [7:0] sum;

  always_comb begin
    sum = frame_byte(frame, HUM_INT_LSB) + frame_byte(frame, HUM_DEC_LSB)
        + frame_byte(frame, TMP_INT_LSB) + frame_byte(frame, TMP_DEC_LSB);
    ok  = (sum == frame_byte(frame, CSUM_LSB));
  end

endmodule

// File: rtl/dht11_result_decoder.sv
// Request/response wrapper around a DHT11 driver: starts a read, waits with a
// timeout, validates the checksum and reports one selected reading.
// Optional macro DHT11_RETRY_EN re-issues failed reads up to MAX_RETRIES times.
//
// Handshake: req is a level sampled only in IDLE (ignored while busy);
// sensor_start and valid are single-cycle pulses with no back-pressure;
// status/int_part/dec_part change only in the cycle valid is high.
module dht11_result_decoder
  import dht11_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000000,
  parameter int MAX_RETRIES    = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req,
  input  logic        sel,
  output logic        busy,
  output logic        sensor_start,
  input  logic [39:0] sensor_data,
  input  logic        sensor_done,
  input  logic        sensor_error,
  output logic        valid,
  output logic [1:0]  status,
  output logic [7:0]  int_part,
  output logic [7:0]  dec_part,
  output logic [7:0]  err_count,
  output logic [2:0]  fsm_state
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  if (TIMEOUT_CYCLES < 1 || MAX_RETRIES < 0) begin : g_bad_param
    $error("dht11_result_decoder: TIMEOUT_CYCLES must be >= 1 and MAX_RETRIES >= 0");
  end

  state_t        state;
  logic [TW-1:0] timer;
  logic [39:0]   frame;
  logic          sel_q;
  logic          sum_ok;
  logic          fail;
  logic [1:0]    fail_code;
  logic          retry;

  dht11_checksum u_checksum (
    .frame (frame),
    .ok    (sum_ok)
  );

  // An error wins over a simultaneous done; done wins over a timeout.
  always_comb begin
    fail      = 1'b0;
    fail_code = ST_OK;
    case (state)
      S_WAIT: begin
        if (sensor_error) begin
          fail      = 1'b1;
          fail_code = ST_SENSOR;
        end else if (!sensor_done && timer == TIMER_LAST) begin
          fail      = 1'b1;
          fail_code = ST_TIMEOUT;
        end
      end
      S_CHECK: begin
        if (!sum_ok) begin
          fail      = 1'b1;
          fail_code = ST_CHECKSUM;
        end
      end
      default: ;
    endcase
  end

`ifdef DHT11_RETRY_EN
  localparam int AW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
  logic [AW-1:0] attempt;
  assign retry = fail && (attempt < AW'(MAX_RETRIES));

  always_ff @(posedge clock) begin
    if (reset) begin
      attempt <= '0;
    end else if (state == S_IDLE && req) begin
      attempt <= '0;
    end else if (retry) begin
      attempt <= attempt + 1'b1;
    end
  end
`else
  assign retry = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= S_IDLE;
      timer        <= '0;
      frame        <= '0;
      sel_q        <= 1'b0;
      busy         <= 1'b0;
      sensor_start <= 1'b0;
      valid        <= 1'b0;
      status       <= ST_OK;
      int_part     <= 8'h00;
      dec_part     <= 8'h00;
      err_count    <= 8'h00;
    end else begin
      sensor_start <= 1'b0;
      valid        <= 1'b0;
      if (fail) begin
        if (retry) begin
          state        <= S_START;
          sensor_start <= 1'b1;
        end else begin
          state    <= S_RESPOND;
          valid    <= 1'b1;
          status   <= fail_code;
          int_part <= 8'h00;
          dec_part <= 8'h00;
          if (err_count != 8'hFF) err_count <= err_count + 8'h01;
        end
      end else begin
        case (state)
          S_IDLE: begin
            if (req) begin
              sel_q        <= sel;
              state        <= S_START;
              sensor_start <= 1'b1;
              busy         <= 1'b1;
            end
          end
          S_START: begin
            timer <= '0;
            state <= S_WAIT;
          end
          S_WAIT: begin
            if (sensor_done) begin
              frame <= sensor_data;
              state <= S_CHECK;
            end else begin
              timer <= timer + 1'b1;
            end
          end
          S_CHECK: begin
            state    <= S_RESPOND;
            valid    <= 1'b1;
            status   <= ST_OK;
            int_part <= frame_byte(frame, sel_q ? TMP_INT_LSB : HUM_INT_LSB);
            dec_part <= frame_byte(frame, sel_q ? TMP_DEC_LSB : HUM_DEC_LSB);
          end
          S_RESPOND: begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
          default: begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign fsm_state = state;

endmodule

// File: tb/tb_dht11_result_decoder.sv
// Self-checking bench for dht11_result_decoder: table of transactions, a
// sensor model reacting to sensor_start, and a valid-side scoreboard.
`timescale 1ns/1ps
module tb_dht11_result_decoder;

  localparam int TIMEOUT = 100;
  localparam int RETRIES = 2;
`ifdef DHT11_RETRY_EN
  localparam int EFF_RETRIES = RETRIES;
`else
  localparam int EFF_RETRIES = 0;
`endif

  localparam int K_DONE = 0;
  localparam int K_ERR  = 1;
  localparam int K_TO   = 2;
  localparam int K_BOTH = 3;

  localparam logic [39:0] GOOD = 40'h3A00190558;
  localparam logic [39:0] BAD  = 40'h3A00190559;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req = 1'b0;
  logic        sel = 1'b0;
  logic [39:0] sensor_data = '0;
  logic        sensor_done = 1'b0;
  logic        sensor_error = 1'b0;
  logic        busy, sensor_start, valid;
  logic [1:0]  status;
  logic [7:0]  int_part, dec_part, err_count;
  logic [2:0]  fsm_state;

  dht11_result_decoder #(.TIMEOUT_CYCLES(TIMEOUT), .MAX_RETRIES(RETRIES)) dut (
    .clock(clock), .reset(reset), .req(req), .sel(sel), .busy(busy),
    .sensor_start(sensor_start), .sensor_data(sensor_data),
    .sensor_done(sensor_done), .sensor_error(sensor_error), .valid(valid),
    .status(status), .int_part(int_part), .dec_part(dec_part),
    .err_count(err_count), .fsm_state(fsm_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  int start_count = 0;
  int valid_count = 0;
  logic [7:0]  err_model = 8'h00;
  logic [25:0] exp_q[$];
  logic [25:0] exp_e;

  task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (!reset) begin
      if (sensor_start) start_count++;
      if (valid) begin
        valid_count++;
        if (exp_q.size() == 0) begin
          chk("unexpected_valid", 40'd1, 40'd0);
        end else begin
          exp_e = exp_q.pop_front();
          chk("status", 40'(status), 40'(exp_e[25:24]));
          chk("int_part", 40'(int_part), 40'(exp_e[23:16]));
          chk("dec_part", 40'(dec_part), 40'(exp_e[15:8]));
          chk("err_count", 40'(err_count), 40'(exp_e[7:0]));
        end
      end
    end
  end

  // ---------------- driver ----------------
  function automatic int beh(input int i, input int pre_err, input int kind);
    return (i < pre_err) ? K_ERR : kind;
  endfunction

  function automatic bit attempt_fails(input int b, input logic [39:0] f);
    logic [7:0] s;
    s = f[39:32] + f[31:24] + f[23:16] + f[15:8];
    return (b != K_DONE) || (s != f[7:0]);
  endfunction

  task automatic run_txn(input logic s, input int kind, input logic [39:0] frame,
                         input int pre_err, input logic [1:0] est,
                         input logic [7:0] eip, input logic [7:0] edp);
    int final_i, s0, n, d, b, lat;
    bit got_valid, got_start;
    final_i = 0;
    while (final_i < EFF_RETRIES && attempt_fails(beh(final_i, pre_err, kind), frame))
      final_i++;
    if (est != 2'b00 && err_model != 8'hFF) err_model = err_model + 8'h01;
    exp_q.push_back({est, eip, edp, err_model});
    s0 = start_count;
    @(negedge clock);
    req = 1'b1;
    sel = s;
    @(negedge clock);
    req = 1'b0;
    sel = 1'($urandom_range(0, 1));
    chk("start_latency", 40'(sensor_start), 40'd1);
    for (int i = 0; i <= final_i; i++) begin
      b = beh(i, pre_err, kind);
      d = $urandom_range(1, 4);
      n = 0;
      got_valid = 0;
      got_start = 0;
      while (n < TIMEOUT + 20 && !got_valid && !got_start) begin
        @(negedge clock);
        n++;
        if (b != K_TO) begin
          if (n == d) begin
            sensor_data  = (b == K_DONE) ? frame : 40'($urandom());
            sensor_done  = (b == K_DONE || b == K_BOTH);
            sensor_error = (b == K_ERR || b == K_BOTH);
          end else if (n == d + 1) begin
            sensor_done  = 1'b0;
            sensor_error = 1'b0;
          end
        end
        if (sensor_start) got_start = 1;
        if (valid) got_valid = 1;
      end
      sensor_done  = 1'b0;
      sensor_error = 1'b0;
      if (i < final_i) begin
        chk("retry_restart", 40'(got_start), 40'd1);
        if (!got_start) break;
      end else begin
        chk("valid_seen", 40'(got_valid), 40'd1);
        lat = (b == K_TO) ? TIMEOUT + 1 : (b == K_DONE) ? d + 2 : d + 1;
        if (got_valid) chk("valid_latency", 40'(n), 40'(lat));
      end
    end
    @(negedge clock);
    chk("busy_after", 40'(busy), 40'd0);
    chk("start_pulses", 40'(start_count - s0), 40'(final_i + 1));
    chk("scoreboard_empty", 40'(exp_q.size()), 40'd0);
    exp_q.delete();
  endtask

  // ---------------- test ----------------
  typedef struct {
    logic        s;
    int          kind;
    logic [39:0] frame;
    logic [1:0]  st;
    logic [7:0]  ip;
    logic [7:0]  dp;
  } vec_t;

  vec_t tbl[9];
  int   s0, v0;

  initial begin
    tbl[0] = '{1'b1, K_DONE, GOOD,           2'b00, 8'h19, 8'h05};
    tbl[1] = '{1'b0, K_DONE, GOOD,           2'b00, 8'h3A, 8'h00};
    tbl[2] = '{1'b0, K_DONE, BAD,            2'b01, 8'h00, 8'h00};
    tbl[3] = '{1'b1, K_ERR,  GOOD,           2'b10, 8'h00, 8'h00};
    tbl[4] = '{1'b0, K_TO,   GOOD,           2'b11, 8'h00, 8'h00};
    tbl[5] = '{1'b1, K_BOTH, GOOD,           2'b10, 8'h00, 8'h00};
    tbl[6] = '{1'b1, K_DONE, 40'hFFFF010201, 2'b00, 8'h01, 8'h02};
    tbl[7] = '{1'b0, K_DONE, 40'h0000000000, 2'b00, 8'h00, 8'h00};
    tbl[8] = '{1'b0, K_DONE, 40'h1234567814, 2'b00, 8'h12, 8'h34};

    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("rst_busy", 40'(busy), 40'd0);
    chk("rst_start", 40'(sensor_start), 40'd0);
    chk("rst_valid", 40'(valid), 40'd0);
    chk("rst_status", 40'(status), 40'd0);
    chk("rst_int", 40'(int_part), 40'd0);
    chk("rst_dec", 40'(dec_part), 40'd0);
    chk("rst_err", 40'(err_count), 40'd0);
    chk("rst_state", 40'(fsm_state), 40'd0);

    for (int i = 0; i < 9; i++)
      run_txn(tbl[i].s, tbl[i].kind, tbl[i].frame, 0, tbl[i].st, tbl[i].ip, tbl[i].dp);

    // req while busy is ignored, then reset abandons the transaction in WAIT
    s0 = start_count;
    @(negedge clock);
    req = 1'b1;
    @(negedge clock);
    req = 1'b0;
    repeat (2) @(negedge clock);
    req = 1'b1;
    @(negedge clock);
    req = 1'b0;
    @(negedge clock);
    chk("req_busy_ignored", 40'(start_count - s0), 40'd1);
    chk("busy_in_wait", 40'(busy), 40'd1);
    v0 = valid_count;
    reset = 1'b1;
    @(negedge clock);
    chk("mid_rst_busy", 40'(busy), 40'd0);
    chk("mid_rst_valid", 40'(valid), 40'd0);
    chk("mid_rst_status", 40'(status), 40'd0);
    chk("mid_rst_int", 40'(int_part), 40'd0);
    chk("mid_rst_dec", 40'(dec_part), 40'd0);
    chk("mid_rst_err", 40'(err_count), 40'd0);
    reset = 1'b0;
    err_model = 8'h00;
    sensor_data = GOOD;
    sensor_done = 1'b1;
    @(negedge clock);
    sensor_done = 1'b0;
    repeat (4) @(negedge clock);
    chk("late_done_ignored", 40'(valid_count - v0), 40'd0);
    chk("idle_after_rst", 40'(busy), 40'd0);

`ifdef DHT11_RETRY_EN
    run_txn(1'b1, K_DONE, GOOD, 2, 2'b00, 8'h19, 8'h05);
    run_txn(1'b0, K_DONE, GOOD, 3, 2'b10, 8'h00, 8'h00);
`endif

    for (int i = 0; i < 256; i++)
      run_txn(1'($urandom_range(0, 1)), K_DONE, BAD, 0, 2'b01, 8'h00, 8'h00);
    chk("err_saturated", 40'(err_count), 40'hFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dht11_result_decoder.md
DHT11_RESULT_DECODER -- requirements
Module: dht11_result_decoder

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 50000000, max clock cycles to wait for sensor_done or sensor_error per attempt (1 s at 50 MHz).
REQ-002 SHALL have parameter MAX_RETRIES, default 2, extra attempts after a failed one; used only with DHT11_RETRY_EN.
REQ-003 SHALL have ports, clock and reset first: clock in 1, system clock; reset in 1, reset.
REQ-004 SHALL use one clock; reset is synchronous and active-high.
REQ-005 SHALL have ports: req in 1, measurement request pulse; sel in 1, 0=humidity, 1=temperature; busy out 1, transaction in progress.
REQ-006 SHALL have ports: sensor_start out 1, one-cycle start pulse to sensor driver; sensor_data in 40, raw frame; sensor_done in 1, frame valid; sensor_error in 1, driver fault.
REQ-007 SHALL have ports: valid out 1, result pulse; status out 2, 00 OK, 01 checksum, 10 sensor error, 11 timeout; int_part out 8; dec_part out 8; err_count out 8, saturating fault counter.

Function
REQ-008 SHALL implement FSM states IDLE, START, WAIT, CHECK, RESPOND.
REQ-009 IDLE: busy=0; req=1 latches sel, clears attempt counter, goes to START; req in any other state ignored.
REQ-010 START: sensor_start=1 for exactly this one cycle, clears timer, goes to WAIT; busy=1 in all non-IDLE states.
REQ-011 WAIT: sensor_error=1 -> fail with status 10; else sensor_done=1 -> latch sensor_data, go to CHECK; else timer reaching TIMEOUT_CYCLES-1 -> fail with status 11; else timer increments.
REQ-012 sensor_error and sensor_done in the same cycle SHALL be treated as sensor error (status 10).
REQ-013 Frame layout: [39:32] humidity int, [31:24] humidity dec, [23:16] temperature int, [15:8] temperature dec, [7:0] checksum.
REQ-014 CHECK: sum of the four data bytes modulo 256 equal to [7:0] -> RESPOND with status 00; else fail with status 01.
REQ-015 On OK, RESPOND SHALL drive int_part/dec_part with the humidity bytes (sel=0) or temperature bytes (sel=1); on any failure both SHALL be 0x00.
REQ-016 RESPOND: valid=1 for exactly one cycle, status/int_part/dec_part updated in the same cycle, then IDLE; outputs hold until the next RESPOND.
REQ-017 Latency: sensor_done sampled at edge k -> valid high during cycle k+2 (CHECK at k+1); req sampled at edge n -> sensor_start high during cycle n+1.
REQ-018 err_count SHALL increment by 1 at each RESPOND with status != 00 and saturate at 0xFF.

Reset
REQ-019 reset=1 at a clock edge SHALL force IDLE from any state, mid-transaction included, and abandon that transaction with no valid pulse.
REQ-020 Reset values: busy=0, sensor_start=0, valid=0, status=00, int_part=0x00, dec_part=0x00, err_count=0x00, timer and attempt counter 0.

Configuration
REQ-021 Macro DHT11_RETRY_EN defined: a failure with attempt counter < MAX_RETRIES SHALL increment the counter and go to START, not RESPOND; err_count counts only the reported final failure.
REQ-022 Macro DHT11_RETRY_EN undefined: every failure goes directly to RESPOND; no attempt counter is synthesised.

Structure
REQ-023 Shared package dht11_pkg SHALL hold the FSM state encoding, the status codes, and frame byte index constants.
REQ-024 Sub-module dht11_checksum (combinational: 40-bit frame in, ok flag out) SHALL be instantiated by the CHECK logic.

Verification
REQ-025 req, sel=1, driver returns 0x3A00190558 -> one sensor_start pulse, then valid with status 00, int_part 0x19, dec_part 0x05; sel=0 gives 0x3A/0x00.
REQ-026 Frame 0x3A00190559, macro off -> status 01, int_part/dec_part 0x00, err_count 0->1.
REQ-027 TIMEOUT_CYCLES=100, no done/error -> valid with status 11 after 100 WAIT cycles; sensor_done and sensor_error in the same cycle -> status 10.
REQ-028 Macro on, MAX_RETRIES=2, sensor_error on attempts 1-2 then 0x3A00190558 -> three sensor_start pulses, single valid with status 00, err_count unchanged; all three faulty -> one status 10, err_count +1.
REQ-029 reset asserted in WAIT -> next cycle busy=0, no valid, outputs at reset values; later sensor_done ignored.
REQ-030 256 forced checksum failures -> err_count holds 0xFF; req while busy -> no second sensor_start.
